// File: rtl/gen_lib_pkg.sv
// Shared types and helpers for the general-purpose signal conditioning library.
package gen_lib_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    QUAL_HI   = 2'd1,
    STABLE_HI = 2'd2,
    QUAL_LO   = 2'd3
  } dbnc_state_t;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain shift-register synchroniser for a single-bit level crossing into clk.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronise an asynchronous bouncy level, qualify it with a consecutive-sample
// counter, and emit a clean level plus one-cycle rise/fall strobes.
module debounce_sync
  import gen_lib_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s;
  logic [CNT_W-1:0] cnt;
  dbnc_state_t      state;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (s)
  );

  // cnt counts consecutive opposite samples; reaching CNT_LAST commits the change,
  // so the counter is left before it could ever wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STABLE_LO;
      cnt   <= '0;
      dout  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        STABLE_LO: begin
          if (s) begin
            state <= QUAL_HI;
            cnt   <= CNT_ONE;
            busy  <= 1'b1;
          end else begin
            cnt  <= '0;
            busy <= 1'b0;
          end
        end
        QUAL_HI: begin
          if (!s) begin
            state <= STABLE_LO;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state <= STABLE_HI;
            cnt   <= '0;
            dout  <= 1'b1;
            rise  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!s) begin
            state <= QUAL_LO;
            cnt   <= CNT_ONE;
            busy  <= 1'b1;
          end else begin
            cnt  <= '0;
            busy <= 1'b0;
          end
        end
        QUAL_LO: begin
          if (s) begin
            state <= STABLE_HI;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state <= STABLE_LO;
            cnt   <= '0;
            dout  <= 1'b0;
            fall  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= STABLE_LO;
          cnt   <= '0;
          dout  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: directed scenarios plus random bouncing input,
// checked every cycle against a run-length reference model.
module tb_debounce_sync;

  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic dout, rise, fall, busy;

  always #5 clk = ~clk;

  debounce_sync #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .dout (dout),
    .rise (rise),
    .fall (fall),
    .busy (busy)
  );

  // ---------------- reference model ----------------
  // The FSM acts on din as it was SYNC_STAGES edges earlier; dout flips once
  // DEBOUNCE_CYCLES consecutive delayed samples disagree with it.
  logic       dly_q[$];
  logic [1:0] exp_q[$];
  logic       m_dout = 1'b0, m_rise = 1'b0, m_fall = 1'b0, m_busy = 1'b0;
  int         m_run = 0;

  always @(posedge clk) begin
    logic smp;
    if (rst) begin
      dly_q.delete();
      for (int i = 0; i < SYNC_STAGES; i++) dly_q.push_back(1'b0);
      m_dout = 1'b0;
      m_rise = 1'b0;
      m_fall = 1'b0;
      m_run  = 0;
    end else begin
      smp = dly_q.pop_front();
      dly_q.push_back(din);
      m_rise = 1'b0;
      m_fall = 1'b0;
      m_run  = (smp != m_dout) ? m_run + 1 : 0;
      if (m_run == DEBOUNCE_CYCLES) begin
        m_dout = smp;
        m_rise = smp;
        m_fall = !smp;
        exp_q.push_back({smp, !smp});
        m_run  = 0;
      end
    end
    m_busy = (m_run != 0);
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_rise   = 0;
  int n_fall   = 0;
  int n_busy   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input logic d, input logic r);
    din = d;
    rst = r;
    @(posedge clk);
    @(negedge clk);
    check_eq("dout", int'(dout), int'(m_dout));
    check_eq("rise", int'(rise), int'(m_rise));
    check_eq("fall", int'(fall), int'(m_fall));
    check_eq("busy", int'(busy), int'(m_busy));
    check_eq("strobe_excl", int'(rise & fall), 0);
    if (rise || fall) begin
      if (exp_q.size() == 0) check_eq("strobe_unexpected", int'({rise, fall}), 0);
      else                   check_eq("strobe_kind", int'({rise, fall}), int'(exp_q.pop_front()));
    end
    if (rise) n_rise++;
    if (fall) n_fall++;
    if (busy) n_busy++;
  endtask

  task automatic hold(input logic d, input int n);
    for (int i = 0; i < n; i++) cyc(d, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    @(negedge clk);

    // 1: din high through reset, then full latency and a single rise
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1);
      check_eq("t1_rst_outs", int'({dout, rise, fall, busy}), 0);
    end
    n_rise = 0;
    for (int i = 1; i <= 6; i++) begin
      cyc(1'b1, 1'b0);
      check_eq("t1_dout", int'(dout), (i == 6) ? 1 : 0);
      check_eq("t1_rise", int'(rise), (i == 6) ? 1 : 0);
    end
    cyc(1'b1, 1'b0);
    check_eq("t1_rise_once", n_rise, 1);

    // 2: clean rising edge from edge k
    hold(1'b0, 8);
    check_eq("t2_start_lo", int'(dout), 0);
    for (int i = 0; i <= 6; i++) begin
      cyc(1'b1, 1'b0);
      check_eq("t2_busy", int'(busy), (i >= 2 && i <= 4) ? 1 : 0);
      check_eq("t2_dout", int'(dout), (i >= 5) ? 1 : 0);
      check_eq("t2_rise", int'(rise), (i == 5) ? 1 : 0);
    end

    // 3: short high pulse is rejected
    hold(1'b0, 8);
    n_rise = 0;
    n_busy = 0;
    hold(1'b1, 3);
    hold(1'b0, 6);
    check_eq("t3_no_rise", n_rise, 0);
    check_eq("t3_busy_seen", int'(n_busy > 0), 1);
    check_eq("t3_busy_end", int'(busy), 0);
    check_eq("t3_dout", int'(dout), 0);

    // 4: bounce then held high from edge j
    n_rise = 0;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    for (int i = 0; i <= 6; i++) begin
      cyc(1'b1, 1'b0);
      check_eq("t4_dout", int'(dout), (i >= 5) ? 1 : 0);
    end
    check_eq("t4_rise_once", n_rise, 1);

    // 5: 2-cycle low glitch ignored, then held low gives a fall
    n_fall = 0;
    hold(1'b0, 2);
    hold(1'b1, 6);
    check_eq("t5_glitch_nofall", n_fall, 0);
    check_eq("t5_glitch_dout", int'(dout), 1);
    for (int i = 0; i <= 6; i++) begin
      cyc(1'b0, 1'b0);
      check_eq("t5_dout", int'(dout), (i >= 5) ? 0 : 1);
      check_eq("t5_fall", int'(fall), (i == 5) ? 1 : 0);
    end
    check_eq("t5_fall_once", n_fall, 1);

    // 6: reset during QUAL_LO with dout high
    hold(1'b1, 8);
    hold(1'b0, 3);
    check_eq("t6_busy_pre", int'(busy), 1);
    check_eq("t6_dout_pre", int'(dout), 1);
    n_fall = 0;
    cyc(1'b0, 1'b1);
    check_eq("t6_rst_outs", int'({dout, rise, fall, busy}), 0);
    hold(1'b0, 8);
    check_eq("t6_no_fall", n_fall, 0);
    check_eq("t6_dout", int'(dout), 0);

    // random bouncing segments with occasional reset
    for (int seg = 0; seg < 200; seg++) begin
      logic d;
      int   len;
      d   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) cyc(d, ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
    end
    hold(1'b0, 10);

    check_eq("exp_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
